// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared types for the instruction/data memory bus arbiter:
//               arbiter state encoding and grant identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_I = 3'd1,
        WAIT_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } arb_state_t;

    // Which requester owns the memory port.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational grant selection between the fetch port and the
//               data port. With ARB_ROUND_ROBIN_EN defined a tie goes to the
//               port not granted last; otherwise the data port always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic i_ibus_req,
    input  logic i_dbus_req,
    input  logic i_last_grant,
    output logic o_grant
);

`ifdef ARB_ROUND_ROBIN_EN
    // Tie alternates against the previous winner; a lone request always wins.
    always_comb begin
        o_grant = GRANT_I;
        if (i_ibus_req && i_dbus_req) begin
            o_grant = (i_last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (i_dbus_req) begin
            o_grant = GRANT_D;
        end
    end
`else
    // Fixed priority: the fetch port only wins when the data port is quiet,
    // so the fetch request and grant history carry no information here.
    logic [1:0] w_unused_inputs;
    assign w_unused_inputs = {i_ibus_req, i_last_grant};

    // Data port has fixed priority over the fetch port.
    always_comb begin
        o_grant = GRANT_I;
        if (i_dbus_req) begin
            o_grant = GRANT_D;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one single-ported memory between the instruction-fetch
//               port and the data port. Latches the winning request into the
//               mem_* registers, runs a req/ack handshake and returns read
//               data while stalling both the loser and the in-flight port.
//               Optional: ARB_ROUND_ROBIN_EN selects alternating tie-break.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ibus_read,
    input  logic [ADDR_WIDTH-1:0]   ibus_address,
    output logic                    ibus_stall,
    output logic [DATA_WIDTH-1:0]   ibus_rddata,
    input  logic                    dbus_read,
    input  logic                    dbus_write,
    input  logic [ADDR_WIDTH-1:0]   dbus_address,
    input  logic [DATA_WIDTH-1:0]   dbus_wrdata,
    input  logic [DATA_WIDTH/8-1:0] dbus_byteenable,
    output logic                    dbus_stall,
    output logic [DATA_WIDTH-1:0]   dbus_rddata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    import mem_bus_arbiter_pkg::*;

    localparam int                    c_be_width = DATA_WIDTH / 8;
    localparam logic [c_be_width-1:0] c_be_all   = '1;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic                    w_dbus_req;
    logic                    w_any_req;
    logic                    w_accept;
    logic                    w_grant;
    logic                    w_last_grant;
    logic                    w_ack_i;
    logic                    w_ack_d;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [c_be_width-1:0]   r_mem_be;
    logic [DATA_WIDTH-1:0]   r_ibus_rddata;
    logic [DATA_WIDTH-1:0]   r_dbus_rddata;

    assign w_dbus_req = dbus_read | dbus_write;
    assign w_any_req  = ibus_read | w_dbus_req;
    assign w_accept   = (r_state == IDLE) && w_any_req;
    // Acks outside the matching WAIT state are spurious and fall out here.
    assign w_ack_i    = (r_state == WAIT_I) && mem_ack;
    assign w_ack_d    = (r_state == WAIT_D) && mem_ack;

    mem_arb_pick u_pick (
        .i_ibus_req   (ibus_read),
        .i_dbus_req   (w_dbus_req),
        .i_last_grant (w_last_grant),
        .o_grant      (w_grant)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // Remember every winner so the next tie goes to the other port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_I;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = GRANT_I;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: grant from IDLE, wait for ack, spend one DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = (w_grant == GRANT_D) ? WAIT_D : WAIT_I;
                end
            end
            WAIT_I: if (mem_ack) w_state_nxt = DONE_I;
            WAIT_D: if (mem_ack) w_state_nxt = DONE_D;
            DONE_I: w_state_nxt = IDLE;
            DONE_D: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Latch the winning request at grant and hold it until the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else if (w_accept) begin
            r_mem_req <= 1'b1;
            if (w_grant == GRANT_D) begin
                r_mem_addr  <= dbus_address;
                r_mem_wdata <= dbus_wrdata;
                r_mem_we    <= dbus_write;
                r_mem_be    <= dbus_write ? dbus_byteenable : c_be_all;
            end else begin
                r_mem_addr  <= ibus_address;
                r_mem_wdata <= '0;
                r_mem_we    <= 1'b0;
                r_mem_be    <= c_be_all;
            end
        end else if (w_ack_i || w_ack_d) begin
            r_mem_req <= 1'b0;
        end
    end

    // Capture read data per port; stores leave the data register untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ibus_rddata <= '0;
            r_dbus_rddata <= '0;
        end else begin
            if (w_ack_i) begin
                r_ibus_rddata <= mem_rdata;
            end
            if (w_ack_d && !r_mem_we) begin
                r_dbus_rddata <= mem_rdata;
            end
        end
    end

    assign ibus_stall  = ibus_read  & (r_state != DONE_I);
    assign dbus_stall  = w_dbus_req & (r_state != DONE_D);
    assign ibus_rddata = r_ibus_rddata;
    assign dbus_rddata = r_dbus_rddata;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_be      = r_mem_be;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. A memory responder
//               with programmable wait states serves the bus; expectations
//               come from a transaction-level model (reference memory,
//               latency formulas, grant-order rules).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        ibus_read;
    logic [31:0] ibus_address;
    logic        ibus_stall;
    logic [31:0] ibus_rddata;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_address;
    logic [31:0] dbus_wrdata;
    logic [3:0]  dbus_byteenable;
    logic        dbus_stall;
    logic [31:0] dbus_rddata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_read(ibus_read), .ibus_address(ibus_address),
        .ibus_stall(ibus_stall), .ibus_rddata(ibus_rddata),
        .dbus_read(dbus_read), .dbus_write(dbus_write),
        .dbus_address(dbus_address), .dbus_wrdata(dbus_wrdata),
        .dbus_byteenable(dbus_byteenable), .dbus_stall(dbus_stall),
        .dbus_rddata(dbus_rddata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] ram     [bit [31:0]];
    logic [31:0] ref_ram [bit [31:0]];
    txn_t        log_q[$];
    int          mem_wait = 0;
    bit          resp_en  = 1'b1;
    int          model_last;
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : dflt(a);
    endfunction

    // Memory responder: acks after mem_wait idle cycles, checks field stability.
    initial begin
        int          wcnt;
        logic        prev_req;
        txn_t        prev_f;
        txn_t        cur_f;
        logic [31:0] old;
        wcnt = 0; prev_req = 1'b0; prev_f = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                mem_ack = 1'b0;
                cur_f = {mem_we, mem_addr, mem_wdata, mem_be};
                if (mem_req && prev_req) begin
                    n_checks++;
                    if (cur_f !== prev_f) begin
                        n_errs++;
                        $display("FAIL mem_stable: fields %h, required unchanged %h", cur_f, prev_f);
                    end
                end
                prev_req = mem_req;
                prev_f   = cur_f;
                if (mem_req) begin
                    if (wcnt >= mem_wait) begin
                        old = ram.exists(cur_f.addr) ? ram[cur_f.addr] : dflt(cur_f.addr);
                        if (cur_f.we) ram[cur_f.addr] = merge(old, cur_f.wdata, cur_f.be);
                        mem_rdata = old;
                        mem_ack   = 1'b1;
                        log_q.push_back(cur_f);
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                wcnt = 0;
                prev_req = 1'b0;
            end
        end
    end

    // One port access; returns cycles from request to stall-low and the read data.
    task automatic port_access(input bit is_d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input bit keep, output int lat, output logic [31:0] rdata);
        int cyc;
        cyc = 0;
        if (is_d) begin
            dbus_read = !wr; dbus_write = wr; dbus_address = addr;
            dbus_wrdata = wdata; dbus_byteenable = be;
        end else begin
            ibus_read = 1'b1; ibus_address = addr;
        end
        do begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end while (((is_d ? dbus_stall : ibus_stall) === 1'b1) && cyc < 200);
        if (cyc >= 200) begin
            n_checks++; n_errs++;
            $display("FAIL timeout: port %0d still stalled after %0d cycles, required completion", is_d, cyc);
        end
        lat   = cyc;
        rdata = is_d ? dbus_rddata : ibus_rddata;
        if (!keep) begin
            if (is_d) begin dbus_read = 1'b0; dbus_write = 1'b0; end
            else ibus_read = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ibus_read = 0; ibus_address = 0; dbus_read = 0; dbus_write = 0;
        dbus_address = 0; dbus_wrdata = 0; dbus_byteenable = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_errs++; $display("FAIL rst_mem_req: got %b required 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_errs++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0) begin n_errs++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_errs++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
        n_checks++; if (mem_be !== 4'h0) begin n_errs++; $display("FAIL rst_mem_be: got %h required 0", mem_be); end
        n_checks++; if (ibus_rddata !== 32'h0) begin n_errs++; $display("FAIL rst_ibus_rddata: got %h required 0", ibus_rddata); end
        n_checks++; if (dbus_rddata !== 32'h0) begin n_errs++; $display("FAIL rst_dbus_rddata: got %h required 0", dbus_rddata); end
        n_checks++; if ({ibus_stall, dbus_stall} !== 2'b00) begin n_errs++; $display("FAIL rst_stalls: got %b required 00", {ibus_stall, dbus_stall}); end
        rst_n = 1'b1;
        model_last = 0; exp_ird = '0; exp_drd = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_errs++; $display("FAIL idle_no_req: mem_req got %b required 0", mem_req); end
    endtask

    task automatic test_single_fetch();
        int lat; logic [31:0] rd;
        ram[32'h1000] = 32'h2402_0001; ref_ram[32'h1000] = 32'h2402_0001;
        mem_wait = 2; log_q.delete();
        port_access(1'b0, 1'b0, 32'h0000_1000, '0, '0, 1'b0, lat, rd);
        n_checks++; if (lat !== 4) begin n_errs++; $display("FAIL fetch_latency: got %0d required 4", lat); end
        n_checks++; if (rd !== 32'h2402_0001) begin n_errs++; $display("FAIL fetch_data: got %h required 24020001", rd); end
        n_checks++; if (log_q.size() !== 1 || log_q[0].we !== 1'b0 || log_q[0].addr !== 32'h1000 || log_q[0].be !== 4'hF) begin
            n_errs++; $display("FAIL fetch_bus: got n=%0d %h required one read at 00001000 be f", log_q.size(), log_q[0]);
        end
        exp_ird = 32'h2402_0001; model_last = 0;
        @(negedge clk);
    endtask

    task automatic test_store();
        int lat; logic [31:0] rd;
        mem_wait = 0; log_q.delete();
        port_access(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011, 1'b0, lat, rd);
        ref_ram[32'h40] = merge(ref_rd(32'h40), 32'hDEAD_BEEF, 4'b0011);
        model_last = 1;
        n_checks++; if (lat !== 2) begin n_errs++; $display("FAIL store_latency: got %0d required 2", lat); end
        n_checks++; if (log_q.size() !== 1 || log_q[0] !== {1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011}) begin
            n_errs++; $display("FAIL store_bus: got n=%0d %h required %h", log_q.size(), log_q[0], {1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011});
        end
        n_checks++; if (rd !== exp_drd) begin n_errs++; $display("FAIL store_rddata_hold: got %h required %h", rd, exp_drd); end
        @(negedge clk);
        port_access(1'b1, 1'b0, 32'h0000_0040, '0, 4'h0, 1'b0, lat, rd);
        n_checks++; if (rd !== ref_rd(32'h40)) begin n_errs++; $display("FAIL store_readback: got %h required %h", rd, ref_rd(32'h40)); end
        exp_drd = ref_rd(32'h40);
        @(negedge clk);
    endtask

    task automatic test_tie();
        int lat_i, lat_d; logic [31:0] rd_i, rd_d; bit win_d;
        mem_wait = 0;
        port_access(1'b1, 1'b0, 32'h8000, '0, 4'h0, 1'b0, lat_d, rd_d);
        model_last = 1; exp_drd = ref_rd(32'h8000);
        @(negedge clk);
        log_q.delete();
        win_d = RR ? (model_last == 0) : 1'b1;
        fork
            port_access(1'b0, 1'b0, 32'h1100, '0, 4'h0, 1'b0, lat_i, rd_i);
            port_access(1'b1, 1'b0, 32'h8100, '0, 4'h0, 1'b0, lat_d, rd_d);
        join
        n_checks++; if (lat_i !== (win_d ? 5 : 2)) begin n_errs++; $display("FAIL tie_lat_i: got %0d required %0d", lat_i, win_d ? 5 : 2); end
        n_checks++; if (lat_d !== (win_d ? 2 : 5)) begin n_errs++; $display("FAIL tie_lat_d: got %0d required %0d", lat_d, win_d ? 2 : 5); end
        n_checks++; if (log_q[0].addr !== (win_d ? 32'h8100 : 32'h1100)) begin n_errs++; $display("FAIL tie_first: got %h required %h", log_q[0].addr, win_d ? 32'h8100 : 32'h1100); end
        n_checks++; if (rd_i !== ref_rd(32'h1100) || rd_d !== ref_rd(32'h8100)) begin
            n_errs++; $display("FAIL tie_data: got %h/%h required %h/%h", rd_i, rd_d, ref_rd(32'h1100), ref_rd(32'h8100));
        end
        exp_ird = ref_rd(32'h1100); exp_drd = ref_rd(32'h8100);
        model_last = win_d ? 0 : 1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int exp_order[$]; int li, ri, rd, g, first_i;
        mem_wait = 0; log_q.delete();
        li = model_last; ri = 3; rd = 7;
        while (ri > 0 || rd > 0) begin
            if (ri > 0 && rd > 0) g = RR ? (1 - li) : 1;
            else g = (rd > 0) ? 1 : 0;
            exp_order.push_back(g);
            li = g;
            if (g == 1) rd--; else ri--;
        end
        first_i = 0;
        while (exp_order[first_i] != 0) first_i++;
        fork
            begin
                int lat; logic [31:0] v;
                for (int k = 0; k < 7; k++) begin
                    port_access(1'b1, 1'b0, 32'h8200 + 32'(4*k), '0, 4'h0, (k < 6), lat, v);
                    n_checks++; if (v !== ref_rd(32'h8200 + 32'(4*k))) begin n_errs++; $display("FAIL b2b_d_data%0d: got %h required %h", k, v, ref_rd(32'h8200 + 32'(4*k))); end
                end
            end
            begin
                int lat; logic [31:0] v;
                for (int k = 0; k < 3; k++) begin
                    port_access(1'b0, 1'b0, 32'h1200 + 32'(4*k), '0, 4'h0, (k < 2), lat, v);
                    if (k == 0) begin
                        n_checks++; if (lat !== 3*first_i + 2) begin n_errs++; $display("FAIL b2b_fetch_wait: got %0d required %0d", lat, 3*first_i + 2); end
                    end
                    n_checks++; if (v !== ref_rd(32'h1200 + 32'(4*k))) begin n_errs++; $display("FAIL b2b_i_data%0d: got %h required %h", k, v, ref_rd(32'h1200 + 32'(4*k))); end
                end
            end
        join
        n_checks++; if (log_q.size() !== 10) begin n_errs++; $display("FAIL b2b_count: got %0d required 10", log_q.size()); end
        for (int k = 0; k < 10 && k < log_q.size(); k++) begin
            n_checks++;
            if ((log_q[k].addr >= 32'h8000) !== (exp_order[k] == 1)) begin
                n_errs++; $display("FAIL b2b_order%0d: got addr %h required port %0d", k, log_q[k].addr, exp_order[k]);
            end
        end
        exp_ird = ref_rd(32'h1208); exp_drd = ref_rd(32'h8218);
        model_last = li;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        resp_en = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        dbus_read = 1'b1; dbus_address = 32'h8300;
        @(posedge clk); @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_errs++; $display("FAIL rmid_req_up: got %b required 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_errs++; $display("FAIL rmid_async_drop: got %b required 0", mem_req); end
        dbus_read = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_last = 0; exp_ird = '0; exp_drd = '0;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk); mem_ack = 1'b0;
        n_checks++; if (dbus_rddata !== 32'h0 || ibus_rddata !== 32'h0) begin
            n_errs++; $display("FAIL rmid_late_ack_data: got %h/%h required 0/0", ibus_rddata, dbus_rddata);
        end
        n_checks++; if (mem_req !== 1'b0 || dbus_stall !== 1'b0) begin
            n_errs++; $display("FAIL rmid_late_ack_req: got req %b stall %b required 0 0", mem_req, dbus_stall);
        end
        @(negedge clk);
        resp_en = 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int mode, w, lat_i, lat_d, el_i, el_d, didx;
            bit do_i, do_d, d_wr, win_d;
            logic [31:0] ai, ad, wd, v_i, v_d, exp_v;
            logic [3:0] be;
            mode = $urandom_range(0, 2); w = $urandom_range(0, 3);
            do_i = (mode != 1); do_d = (mode != 0); d_wr = $urandom_range(0, 1);
            ai = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            ad = 32'h8000 + 32'(4 * $urandom_range(0, 15));
            wd = $urandom; be = 4'($urandom_range(1, 15));
            mem_wait = w; log_q.delete();
            win_d = (do_i && do_d) ? (RR ? (model_last == 0) : 1'b1) : do_d;
            exp_v = ref_rd(ad);
            lat_i = 0; lat_d = 0;
            fork
                begin if (do_i) port_access(1'b0, 1'b0, ai, '0, 4'h0, 1'b0, lat_i, v_i); end
                begin if (do_d) port_access(1'b1, d_wr, ad, wd, be, 1'b0, lat_d, v_d); end
            join
            el_i = (do_d && win_d) ? 5 + 2*w : 2 + w;
            el_d = (do_i && !win_d) ? 5 + 2*w : 2 + w;
            if (do_i) begin
                n_checks++; if (lat_i !== el_i) begin n_errs++; $display("FAIL rnd%0d_lat_i: got %0d required %0d", it, lat_i, el_i); end
                n_checks++; if (v_i !== ref_rd(ai)) begin n_errs++; $display("FAIL rnd%0d_data_i: got %h required %h", it, v_i, ref_rd(ai)); end
                exp_ird = ref_rd(ai);
            end
            if (do_d) begin
                n_checks++; if (lat_d !== el_d) begin n_errs++; $display("FAIL rnd%0d_lat_d: got %0d required %0d", it, lat_d, el_d); end
                didx = (do_i && !win_d) ? 1 : 0;
                n_checks++;
                if (log_q[didx].we !== d_wr || log_q[didx].addr !== ad || log_q[didx].be !== (d_wr ? be : 4'hF) ||
                    (d_wr && log_q[didx].wdata !== wd)) begin
                    n_errs++; $display("FAIL rnd%0d_dbus_txn: got %h required we=%b addr=%h be=%h wdata=%h", it, log_q[didx], d_wr, ad, d_wr ? be : 4'hF, wd);
                end
                if (d_wr) ref_ram[ad] = merge(exp_v, wd, be);
                else exp_drd = exp_v;
            end
            n_checks++; if (ibus_rddata !== exp_ird || dbus_rddata !== exp_drd) begin
                n_errs++; $display("FAIL rnd%0d_hold: got %h/%h required %h/%h", it, ibus_rddata, dbus_rddata, exp_ird, exp_drd);
            end
            model_last = (do_i && do_d) ? (win_d ? 0 : 1) : (do_d ? 1 : 0);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
